bram_mac_stage: RTL and testbench

//  Compute stage directly downstream of control_unit. Consumes enable_cu, write_mode and address.

---
 rtl/bram_mac_if.sv | 45 ++++
 rtl/bram_mac_stage.sv | 140 ++++++++++++++
 tb/tb_bram_mac_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bram_mac_if.sv
// bram_mac_if
//   Bundles the control-unit issue port, the host load port and the
//   valid/ready result port of bram_mac_stage.
//   master : the environment (control unit, host loader, result consumer)
//   slave  : bram_mac_stage
// Signals
//   enable_cu, write_mode, address      : read-issue from the control unit
//   wr_en, wr_addr, wr_data_a, wr_data_b: host load of operand memories A/B
//   result, result_valid, result_ready  : dot-product hand-off
//   busy, overrun                       : status
interface bram_mac_if #(
  parameter int BRAM_DEPTH = 2,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 2*DATA_W + BRAM_DEPTH
);
  // A zero-bit address is not representable; a frame of one still needs a port.
  localparam int AW = (BRAM_DEPTH > 0) ? BRAM_DEPTH : 1;

  logic                     enable_cu;
  logic                     write_mode;
  logic        [AW-1:0]     address;
  logic                     wr_en;
  logic        [AW-1:0]     wr_addr;
  logic signed [DATA_W-1:0] wr_data_a;
  logic signed [DATA_W-1:0] wr_data_b;
  logic signed [ACC_W-1:0]  result;
  logic                     result_valid;
  logic                     result_ready;
  logic                     busy;
  logic                     overrun;

  modport master (
    output enable_cu, write_mode, address,
    output wr_en, wr_addr, wr_data_a, wr_data_b,
    output result_ready,
    input  result, result_valid, busy, overrun
  );

  modport slave (
    input  enable_cu, write_mode, address,
    input  wr_en, wr_addr, wr_data_a, wr_data_b,
    input  result_ready,
    output result, result_valid, busy, overrun
  );
endinterface

// File: rtl/bram_mac_stage.sv
// bram_mac_stage
//   Compute stage behind the control unit. Two host-loaded operand memories
//   A and B are read in lockstep at the control-unit address; the signed
//   products of one frame (2**BRAM_DEPTH reads) are summed and the dot product
//   is handed off on a valid/ready port.
// Ports
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : bram_mac_if.slave (issue, host load, result hand-off, status)
module bram_mac_stage #(
  parameter int BRAM_DEPTH = 2,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 2*DATA_W + BRAM_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  bram_mac_if.slave bus
);

  localparam int            DEPTH = 1 << BRAM_DEPTH;
  localparam int            CW    = BRAM_DEPTH + 1;
  localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  function automatic logic signed [2*DATA_W-1:0] mul_s(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] ea;
    logic signed [2*DATA_W-1:0] eb;
    ea = {{DATA_W{a[DATA_W-1]}}, a};
    eb = {{DATA_W{b[DATA_W-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_prod(
    input logic signed [2*DATA_W-1:0] p
  );
    return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
  endfunction

  state_t                   r_state;
  logic        [CW-1:0]     r_count;
  logic                     r_vld_p0;
  logic                     r_vld_p1;
  logic signed [DATA_W-1:0] r_mem_a [DEPTH];
  logic signed [DATA_W-1:0] r_mem_b [DEPTH];
  logic signed [DATA_W-1:0] r_a_p0;
  logic signed [DATA_W-1:0] r_b_p0;
  logic signed [2*DATA_W-1:0] r_prod_p1;
  logic signed [ACC_W-1:0]  r_acc_p2;
  logic signed [ACC_W-1:0]  r_result;
  logic                     r_result_valid;
  logic                     r_overrun;

  logic w_issue;
  logic w_accept;
  logic w_wr;

  assign w_issue  = bus.enable_cu & ~bus.write_mode;
  assign w_accept = w_issue & ((r_state == IDLE) | (r_state == ACCUM));
  // Memories are frozen while a frame is in flight so one frame sees one data set.
  assign w_wr     = bus.wr_en & ((r_state == IDLE) | (r_state == DONE));

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_a[bus.wr_addr] <= bus.wr_data_a;
      r_mem_b[bus.wr_addr] <= bus.wr_data_b;
    end
  end

  always_ff @(posedge clk) begin
    // p0: read-first registered operands
    r_a_p0    <= r_mem_a[bus.address];
    r_b_p0    <= r_mem_b[bus.address];
    // p1: signed product
    r_prod_p1 <= mul_s(r_a_p0, r_b_p0);
    // p2: accumulate; cleared by the issue that opens a frame
    if ((r_state == IDLE) && w_issue)
      r_acc_p2 <= '0;
    else if (r_vld_p1)
      r_acc_p2 <= r_acc_p2 + sext_prod(r_prod_p1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_vld_p0       <= 1'b0;
      r_vld_p1       <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept;
      r_vld_p1 <= r_vld_p0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_count <= CW'(1);
            r_state <= (BRAM_DEPTH == 0) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (w_issue) begin
            r_count <= r_count + 1'b1;
            if (r_count == LAST)
              r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_issue)
            r_overrun <= 1'b1;
          // Once the product stage is empty the last add has already landed in acc.
          if (!r_vld_p0 && !r_vld_p1) begin
            r_result       <= r_acc_p2;
            r_result_valid <= 1'b1;
            r_state        <= DONE;
          end
        end
        DONE: begin
          if (w_issue)
            r_overrun <= 1'b1;
          if (bus.result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = (r_state == ACCUM) | (r_state == DRAIN);
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_bram_mac_stage.sv
module tb_bram_mac_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bram_mac_if #(.BRAM_DEPTH(2), .DATA_W(8)) bus ();

  bram_mac_stage #(.BRAM_DEPTH(2), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load4(input int a0, input int a1, input int a2, input int a3,
                       input int b0, input int b1, input int b2, input int b3);
    int av[4];
    int bv[4];
    av = '{a0, a1, a2, a3};
    bv = '{b0, b1, b2, b3};
    for (int i = 0; i < 4; i++) begin
      bus.wr_en     = 1'b1;
      bus.wr_addr   = 2'(i);
      bus.wr_data_a = 8'(av[i]);
      bus.wr_data_b = 8'(bv[i]);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic issue(input int addr);
    bus.enable_cu  = 1'b1;
    bus.write_mode = 1'b0;
    bus.address    = 2'(addr);
    tick();
    bus.enable_cu  = 1'b0;
  endtask

  task automatic frame4();
    for (int i = 0; i < 4; i++) issue(i);
  endtask

  // Edges from the last issue's sampling edge until result_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.result_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic accept();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    bus.enable_cu    = 1'b0;
    bus.write_mode   = 1'b0;
    bus.address      = '0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data_a    = '0;
    bus.wr_data_b    = '0;
    bus.result_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_result", int'(bus.result), 0);
    chk("rst_valid", int'(bus.result_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overrun", int'(bus.overrun), 0);

    // T1 basic
    load4(1, 2, 3, 4, 5, 6, 7, 8);
    issue(0);
    chk("t1_busy", int'(bus.busy), 1);
    issue(1);
    issue(2);
    issue(3);
    tick();
    chk("t1_valid_l2", int'(bus.result_valid), 0);
    tick();
    chk("t1_valid_l3", int'(bus.result_valid), 0);
    tick();
    chk("t1_valid_l4", int'(bus.result_valid), 1);
    chk("t1_result", int'($signed(bus.result)), 70);
    chk("t1_busy_done", int'(bus.busy), 0);
    accept();
    chk("t1_valid_drop", int'(bus.result_valid), 0);

    // T2 signed extremes
    load4(-128, -128, -128, -128, -128, -128, -128, -128);
    frame4();
    wait_valid(lat);
    chk("t2_lat", lat, 3);
    chk("t2_result_max", int'($signed(bus.result)), 65536);
    accept();
    load4(-1, 2, -3, 4, 1, 1, 1, 1);
    frame4();
    wait_valid(lat);
    chk("t2_result_mix", int'($signed(bus.result)), 2);
    accept();

    // T3 gaps and write_mode
    load4(1, 2, 3, 4, 5, 6, 7, 8);
    issue(0);
    tick();
    bus.enable_cu  = 1'b1;
    bus.write_mode = 1'b1;
    bus.address    = 2'd3;
    tick();
    bus.enable_cu  = 1'b0;
    bus.write_mode = 1'b0;
    issue(1);
    bus.enable_cu  = 1'b1;
    bus.write_mode = 1'b1;
    tick();
    bus.enable_cu  = 1'b0;
    bus.write_mode = 1'b0;
    tick();
    issue(2);
    tick();
    tick();
    tick();
    chk("t3_busy_mid", int'(bus.busy), 1);
    chk("t3_valid_mid", int'(bus.result_valid), 0);
    issue(3);
    wait_valid(lat);
    chk("t3_lat", lat, 3);
    chk("t3_result", int'($signed(bus.result)), 70);

    // T4 backpressure
    for (int i = 0; i < 10; i++) tick();
    chk("t4_valid_held", int'(bus.result_valid), 1);
    chk("t4_result_held", int'($signed(bus.result)), 70);
    chk("t4_overrun_pre", int'(bus.overrun), 0);
    issue(0);
    chk("t4_overrun", int'(bus.overrun), 1);
    chk("t4_result_kept", int'($signed(bus.result)), 70);
    chk("t4_valid_kept", int'(bus.result_valid), 1);
    accept();
    chk("t4_valid_drop", int'(bus.result_valid), 0);

    // T5 reset mid-frame
    issue(0);
    issue(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_overrun_clr", int'(bus.overrun), 0);
    chk("t5_busy_clr", int'(bus.busy), 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t5_no_partial", int'(bus.result_valid), 0);
    frame4();
    wait_valid(lat);
    chk("t5_lat", lat, 3);
    chk("t5_result", int'($signed(bus.result)), 70);
    chk("t5_overrun", int'(bus.overrun), 0);
    accept();

    // T6 host write hazards: write during ACCUM is dropped
    issue(0);
    issue(1);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 2'd3;
    bus.wr_data_a = 8'sd100;
    bus.wr_data_b = 8'sd100;
    issue(2);
    bus.wr_en     = 1'b0;
    issue(3);
    wait_valid(lat);
    chk("t6_accum_wr", int'($signed(bus.result)), 70);
    accept();
    frame4();
    wait_valid(lat);
    chk("t6_old_data", int'($signed(bus.result)), 70);
    accept();

    // Write with the first issue in IDLE: write lands, read sees old word
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 2'd0;
    bus.wr_data_a = 8'sd10;
    bus.wr_data_b = 8'sd10;
    issue(0);
    bus.wr_en     = 1'b0;
    issue(1);
    issue(2);
    issue(3);
    wait_valid(lat);
    chk("t6_rd_first", int'($signed(bus.result)), 70);
    accept();
    frame4();
    wait_valid(lat);
    chk("t6_new_data", int'($signed(bus.result)), 165);
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
